// File: rtl/multiword_addsub_sequencer_pkg.sv
// Shared definitions for the multi-word add/subtract sequencer.
package multiword_addsub_sequencer_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_RUN  = 2'd1;
  localparam state_t ST_DONE = 2'd2;

  // Chunk-index width; WORDS is always >= 2, so the result is never zero.
  function automatic int unsigned idx_width(input int unsigned words);
    return $clog2(words);
  endfunction

endpackage

// File: rtl/multiword_addsub_sequencer_slice.sv
// One N-bit add/subtract slice. For subtract, b is inverted here and the
// +1 arrives through c_in from the chained carry register.
module addsub_slice #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  input  logic         add_n,
  input  logic         c_in,
  output logic [N-1:0] s,
  output logic         c_out,
  output logic         c_msb
);

  logic [N-1:0] y_eff;
  logic [N:0]   sum;

  // Ripple sum; carry into the MSB is recovered from the MSB sum bit.
  always_comb begin
    y_eff = y ^ {N{add_n}};
    sum   = {1'b0, x} + {1'b0, y_eff} + {{N{1'b0}}, c_in};
    s     = sum[N-1:0];
    c_out = sum[N];
    c_msb = sum[N-1] ^ x[N-1] ^ y_eff[N-1];
  end

endmodule

// File: rtl/multiword_addsub_sequencer.sv
// Sequences a single N-bit add/subtract slice over WORDS chunks, LSB chunk
// first, chaining the carry through a register.
module multiword_addsub_sequencer
  import multiword_addsub_sequencer_pkg::*;
#(
  parameter int unsigned N     = 4,
  parameter int unsigned WORDS = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               add_n,
  input  logic [N*WORDS-1:0] a,
  input  logic [N*WORDS-1:0] b,
  output logic               ready,
  output logic               done,
  output logic [N*WORDS-1:0] s,
  output logic               c_out,
  output logic               overflow
);

  localparam int unsigned W     = N * WORDS;
  localparam int unsigned IDX_W = idx_width(WORDS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q,   idx_d;
  logic             carry_q, carry_d;
  logic             add_n_q, add_n_d;
  logic [W-1:0]     a_q,     a_d;
  logic [W-1:0]     b_q,     b_d;
  logic [W-1:0]     s_q,     s_d;
  logic             c_out_q, c_out_d;
  logic             ovf_q,   ovf_d;

  logic [N-1:0] sl_x, sl_y, sl_s;
  logic         sl_c_out, sl_c_msb;

  // Select the current chunk of the latched operands for the shared slice.
  always_comb begin
    sl_x = a_q[idx_q*N +: N];
    sl_y = b_q[idx_q*N +: N];
  end

  addsub_slice #(.N(N)) u_slice (
    .x     (sl_x),
    .y     (sl_y),
    .add_n (add_n_q),
    .c_in  (carry_q),
    .s     (sl_s),
    .c_out (sl_c_out),
    .c_msb (sl_c_msb)
  );

  // Next-state logic: accept in IDLE/DONE, one chunk per RUN cycle.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    add_n_d = add_n_q;
    a_d     = a_q;
    b_d     = b_q;
    s_d     = s_q;
    c_out_d = c_out_q;
    ovf_d   = ovf_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          add_n_d = add_n;
          idx_d   = '0;
          carry_d = add_n;
          s_d     = '0;
          c_out_d = 1'b0;
          ovf_d   = 1'b0;
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        s_d[idx_q*N +: N] = sl_s;
        carry_d           = sl_c_out;
        idx_d             = idx_q + 1'b1;
        if (idx_q == LAST_IDX) begin
          c_out_d = sl_c_out;
          ovf_d   = sl_c_msb ^ sl_c_out;
          idx_d   = '0;
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      add_n_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      c_out_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      add_n_q <= add_n_d;
      a_q     <= a_d;
      b_q     <= b_d;
      s_q     <= s_d;
      c_out_q <= c_out_d;
      ovf_q   <= ovf_d;
    end
  end

  // Outputs decoded from the registered state.
  always_comb begin
    ready    = (state_q == ST_IDLE) || (state_q == ST_DONE);
    done     = (state_q == ST_DONE);
    s        = s_q;
    c_out    = c_out_q;
    overflow = ovf_q;
  end

endmodule

// File: tb/tb_multiword_addsub_sequencer.sv
// Self-checking bench for multiword_addsub_sequencer (N=4, WORDS=4).
module tb_multiword_addsub_sequencer;

  localparam int unsigned N     = 4;
  localparam int unsigned WORDS = 4;
  localparam int unsigned W     = N * WORDS;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         add_n;
  logic [W-1:0] a, b;
  logic         ready, done, c_out, overflow;
  logic [W-1:0] s;

  int n_checks = 0;
  int n_fail   = 0;

  multiword_addsub_sequencer #(.N(N), .WORDS(WORDS)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .add_n    (add_n),
    .a        (a),
    .b        (b),
    .ready    (ready),
    .done     (done),
    .s        (s),
    .c_out    (c_out),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: full-width two's-complement arithmetic on plain integers.
  function automatic logic [W+1:0] ref_op(input logic [W-1:0] x, input logic [W-1:0] y,
                                          input logic sub);
    logic [W:0]   full;
    logic [W-1:0] r;
    logic         ov;
    logic         sx, sy, sr;
    if (sub) full = {1'b0, x} + {1'b0, ~y} + (W+1)'(1);
    else     full = {1'b0, x} + {1'b0, y};
    r  = full[W-1:0];
    sx = x[W-1]; sy = y[W-1]; sr = r[W-1];
    if (sub) ov = (sx != sy) && (sr != sx);
    else     ov = (sx == sy) && (sr != sx);
    return {ov, full[W], r};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one op (caller is in IDLE or DONE) and check its result and latency.
  task automatic do_op(input string tag, input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic sub);
    logic [W+1:0] e;
    int cyc;
    e = ref_op(x, y, sub);
    check({tag, ".ready"}, 32'(ready), 32'd1);
    a = x; b = y; add_n = sub; start = 1'b1;
    tick();
    start = 1'b0;
    a = $urandom; b = $urandom; add_n = $urandom_range(0, 1);
    cyc = 0;
    while (!done && cyc < 20) begin
      tick();
      cyc++;
    end
    check({tag, ".latency"}, 32'(cyc), 32'(WORDS));
    check({tag, ".s"},       32'(s),        32'(e[W-1:0]));
    check({tag, ".c_out"},   32'(c_out),    32'(e[W]));
    check({tag, ".ovf"},     32'(overflow), 32'(e[W+1]));
  endtask

  initial begin
    logic [W+1:0] e;
    logic [W-1:0] rx, ry;
    logic         rs;
    rst = 1'b1; start = 1'b0; add_n = 1'b0; a = '0; b = '0;
    tick(); tick();
    rst = 1'b0;
    check("rst.s",     32'(s),        32'd0);
    check("rst.c_out", 32'(c_out),    32'd0);
    check("rst.ovf",   32'(overflow), 32'd0);
    check("rst.done",  32'(done),     32'd0);
    check("rst.ready", 32'(ready),    32'd1);

    // T1..T4 directed cases.
    do_op("t1", 16'h0005, 16'h0006, 1'b0);
    check("t1.s_const", 32'(s), 32'h000B);
    tick();
    check("t1.done_pulse", 32'(done), 32'd0);
    check("t1.s_hold", 32'(s), 32'h000B);
    do_op("t2", 16'h7FFF, 16'h0001, 1'b0);
    check("t2.ovf_const", 32'(overflow), 32'd1);
    tick();
    do_op("t3a", 16'h0005, 16'h0006, 1'b1);
    check("t3a.s_const", 32'(s), 32'hFFFF);
    tick();
    do_op("t3b", 16'h8000, 16'h0001, 1'b1);
    check("t3b.s_const", 32'(s), 32'h7FFF);
    check("t3b.c_const", 32'(c_out), 32'd1);
    tick();
    do_op("t4", 16'hFFFF, 16'h0001, 1'b0);
    check("t4.c_const", 32'(c_out), 32'd1);
    tick();

    // T5: start during RUN is ignored.
    e = ref_op(16'h1111, 16'h2222, 1'b0);
    a = 16'h1111; b = 16'h2222; add_n = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    check("t5.ready_run", 32'(ready), 32'd0);
    a = 16'hABCD; b = 16'h4321; add_n = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    check("t5.done", 32'(done), 32'd1);
    check("t5.s", 32'(s), 32'(e[W-1:0]));
    // Back-to-back accept in the DONE cycle.
    do_op("t5b2b", 16'h0F0F, 16'h00F1, 1'b0);
    tick();
    check("t5.idle_done", 32'(done), 32'd0);

    // T6: reset on the second RUN edge aborts without a done pulse.
    a = 16'h9999; b = 16'h1111; add_n = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t6.s",     32'(s),        32'd0);
    check("t6.c_out", 32'(c_out),    32'd0);
    check("t6.ovf",   32'(overflow), 32'd0);
    check("t6.ready", 32'(ready),    32'd1);
    for (int i = 0; i < 6; i++) begin
      check("t6.no_done", 32'(done), 32'd0);
      tick();
    end
    do_op("t6.after", 16'h1234, 16'h0001, 1'b0);
    check("t6.s_const", 32'(s), 32'h1235);
    tick();

    // Randomised ops with random idle gaps (0 = back-to-back).
    for (int i = 0; i < 60; i++) begin
      rx = 16'($urandom); ry = 16'($urandom); rs = 1'($urandom_range(0, 1));
      if (i % 8 == 0) rx = 16'h8000 ^ 16'($urandom_range(0, 1));
      do_op("rand", rx, ry, rs);
      e = ref_op(rx, ry, rs);
      for (int g = $urandom_range(0, 2); g > 0; g--) begin
        tick();
        check("rand.s_hold", 32'(s), 32'(e[W-1:0]));
        check("rand.ovf_hold", 32'(overflow), 32'(e[W+1]));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
